// File: rtl/ahb_write_master.sv
// ahb_write_master
//
// Purpose:
//   AHB-lite write master used by the AXI-to-AHB bridge. It takes one write
//   command at a time (start address, beat count, size). It pops exactly
//   cmd_len+1 words from the write data FIFO and issues them as an AHB INCR
//   write burst. It then pulses done, with done_err reporting whether any beat
//   drew an ERROR response.
//
// Ports:
//   hclk, resetn            clock and synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only while idle)
//   cmd_addr/len/size       start address, beats-1, log2 bytes per beat
//   fifo_empty/rd_en/rdata  write data FIFO read port (data valid with rd_en)
//   haddr/htrans/hwrite     AHB address phase signals
//   hsize/hburst/hwdata     AHB size, burst type (always INCR), write data
//   hready/hresp            AHB slave handshake and error response
//   done/done_err           one-cycle completion pulse with error status

module ahb_write_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8
) (
  input  logic              hclk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rdata,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  output logic              done,
  output logic              done_err
);

  localparam logic [2:0]   MAX_SIZE  = 3'($clog2(DATA_W / 8));
  localparam logic [1:0]   TR_IDLE   = 2'b00;
  localparam logic [1:0]   TR_BUSY   = 2'b01;
  localparam logic [1:0]   TR_NONSEQ = 2'b10;
  localparam logic [1:0]   TR_SEQ    = 2'b11;
  localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [LEN_W:0]    fetch_left;
  logic [LEN_W:0]    issue_left;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              dphase;
  logic              seg_first;
  logic              err;

  logic              accept;
  logic              done_cond;
  logic              err_cond;
  logic [ADDR_W-1:0] next_addr;

  // Transfer type is decoded from registered state only. Without a word in
  // the hold register a new segment waits in IDLE, while a started segment
  // shows BUSY so the burst is never restarted with NONSEQ mid-segment.
  always_comb begin
    htrans = TR_IDLE;
    if (state == S_ISSUE && issue_left != '0) begin
      if (hold_valid) begin
        htrans = seg_first ? TR_NONSEQ : TR_SEQ;
      end else begin
        htrans = seg_first ? TR_IDLE : TR_BUSY;
      end
    end
  end

  // NONSEQ and SEQ are the only codes with bit 1 set.
  assign accept = hready && htrans[1];

  // The pop refills the hold register as it empties. It does so either on an
  // accepted beat or while the hold register is empty. In DRAIN the words are
  // popped freely and thrown away, which keeps the FIFO aligned to command
  // boundaries.
  assign fifo_rd_en = resetn
                      && (state == S_ISSUE || state == S_DRAIN)
                      && (fetch_left != '0)
                      && !fifo_empty
                      && (!hold_valid || accept || state == S_DRAIN);

  assign cmd_ready = resetn && (state == S_IDLE);
  assign hburst    = 3'b001;
  assign next_addr = haddr + (ADDR_W'(1) << hsize);

  // The final data phase can only be outstanding after every address phase
  // has been issued, so no accept can coincide with completion.
  assign done_cond = dphase && hready && !hresp
                     && (issue_left == '0) && (fetch_left == '0);
  // First cycle of the two-cycle ERROR response.
  assign err_cond  = dphase && hresp && !hready;

  // Main controller: the state register and every registered output.
  always_ff @(posedge hclk) begin
    if (!resetn) begin
      state      <= S_IDLE;
      fetch_left <= '0;
      issue_left <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      dphase     <= 1'b0;
      seg_first  <= 1'b0;
      err        <= 1'b0;
      haddr      <= '0;
      hwdata     <= '0;
      hwrite     <= 1'b0;
      hsize      <= 3'd0;
      done       <= 1'b0;
      done_err   <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            haddr      <= cmd_addr;
            hsize      <= (cmd_size > MAX_SIZE) ? MAX_SIZE : cmd_size;
            fetch_left <= {1'b0, cmd_len} + CNT_ONE;
            issue_left <= {1'b0, cmd_len} + CNT_ONE;
            hold_valid <= 1'b0;
            dphase     <= 1'b0;
            seg_first  <= 1'b1;
            err        <= 1'b0;
            hwrite     <= 1'b1;
            state      <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (fifo_rd_en) begin
            fetch_left <= fetch_left - CNT_ONE;
          end
          if (accept) begin
            hwdata     <= hold_data;
            hold_valid <= fifo_rd_en;
            if (fifo_rd_en) begin
              hold_data <= fifo_rdata;
            end
            haddr      <= next_addr;
            issue_left <= issue_left - CNT_ONE;
            dphase     <= 1'b1;
            // Restart with NONSEQ at each 1 KB boundary.
            seg_first  <= (next_addr[9:0] == 10'd0);
          end else begin
            if (fifo_rd_en) begin
              hold_valid <= 1'b1;
              hold_data  <= fifo_rdata;
            end
            if (dphase && hready) begin
              dphase <= 1'b0;
            end
          end
          if (err_cond) begin
            err    <= 1'b1;
            hwrite <= 1'b0;
            state  <= S_DRAIN;
          end else if (done_cond) begin
            hwrite   <= 1'b0;
            done     <= 1'b1;
            done_err <= err;
            state    <= S_DONE;
          end
        end

        S_DRAIN: begin
          hold_valid <= 1'b0;
          dphase     <= 1'b0;
          if (fifo_rd_en) begin
            fetch_left <= fetch_left - CNT_ONE;
          end
          if (fetch_left == '0) begin
            done     <= 1'b1;
            done_err <= err;
            state    <= S_DONE;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_write_master.sv
// tb_ahb_write_master
//
// Purpose:
//   Self-checking bench for ahb_write_master. A table of command vectors is
//   replayed against a FIFO model and an AHB slave model. Expected address
//   phases and write data are queued when each command is driven and popped
//   as the DUT presents them. Hand-written sequences cover reset.

module tb_ahb_write_master;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 8;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic              hclk = 1'b0;
  logic              resetn;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic [2:0]        cmd_size;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_rdata;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hresp;
  logic              done;
  logic              done_err;

  always #5 hclk = ~hclk;

  ahb_write_master #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .hclk      (hclk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_size  (cmd_size),
    .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en),
    .fifo_rdata(fifo_rdata),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (hready),
    .hresp     (hresp),
    .done      (done),
    .done_err  (done_err)
  );

  // One command vector; cycle numbers are relative to the accept cycle 0.
  typedef struct {
    logic [ADDR_W-1:0] addr;
    int                len;
    logic [2:0]        size;
    int                preload;
    int                push_cycle;
    int                wait_start;
    int                wait_len;
    int                err_cycle;
    int                exp_done;
    bit                exp_err;
    int                exp_beats;
    int                exp_busy;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [1:0]        trans;
  } addr_exp_t;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] late_q[$];
  addr_exp_t         exp_addr_q[$];
  logic [DATA_W-1:0] exp_data_q[$];
  vec_t              vecs[8];
  int                checks;
  int                passed;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mk(input logic [ADDR_W-1:0] addr, input int len,
                              input logic [2:0] size, input int preload,
                              input int push_cycle, input int wait_start,
                              input int wait_len, input int err_cycle,
                              input int exp_done, input bit exp_err,
                              input int exp_beats, input int exp_busy);
    vec_t v;
    v.addr = addr;           v.len = len;               v.size = size;
    v.preload = preload;     v.push_cycle = push_cycle; v.wait_start = wait_start;
    v.wait_len = wait_len;   v.err_cycle = err_cycle;   v.exp_done = exp_done;
    v.exp_err = exp_err;     v.exp_beats = exp_beats;   v.exp_busy = exp_busy;
    return v;
  endfunction

  // Drives the FIFO and slave models for relative cycle c.
  task automatic driveCycle(input vec_t v, input int c);
    if (c == v.push_cycle) begin
      while (late_q.size() > 0) fifo_q.push_back(late_q.pop_front());
    end
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifo_q[0];
    hready = 1'b1;
    hresp  = 1'b0;
    if (c >= v.wait_start && c < v.wait_start + v.wait_len) hready = 1'b0;
    if (v.err_cycle != 0 && c == v.err_cycle) begin
      hready = 1'b0;
      hresp  = 1'b1;
    end
    if (v.err_cycle != 0 && c == v.err_cycle + 1) begin
      hready = 1'b1;
      hresp  = 1'b1;
    end
  endtask

  // Runs one command from the IDLE state through done plus one cycle.
  task automatic applyStimulus(input vec_t v, input int vi);
    int                pops;
    int                beats;
    int                busy;
    int                done_cyc;
    logic              data_pend;
    logic [DATA_W-1:0] data_exp;
    logic [2:0]        exp_size;
    logic [ADDR_W-1:0] a;
    addr_exp_t         e;
    logic [DATA_W-1:0] w;

    pops = 0; beats = 0; busy = 0; done_cyc = -1; data_pend = 1'b0; data_exp = '0;
    exp_size = (v.size > 3'd2) ? 3'd2 : v.size;
    fifo_q.delete(); late_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    for (int i = 0; i <= v.len; i++) begin
      w = 32'hA5A50001 + (vi << 16) + i;
      if (i < v.preload) fifo_q.push_back(w);
      else late_q.push_back(w);
      exp_data_q.push_back(w);
      a = v.addr + i * (1 << exp_size);
      e.addr  = a;
      e.trans = (i == 0 || a[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
      exp_addr_q.push_back(e);
    end

    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = LEN_W'(v.len);
    cmd_size  = v.size;
    for (int c = 0; c <= 60; c++) begin
      driveCycle(v, c);
      @(negedge hclk);
      if (c == 0) checkOutput("cmd_ready_idle", cmd_ready, 1);
      if (c == 1) checkOutput("cmd_ready_busy", cmd_ready, 0);
      if (fifo_rd_en) begin
        pops++;
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      if (data_pend) begin
        checkOutput("hwdata", hwdata, data_exp);
        if (hready) data_pend = 1'b0;
      end
      if (htrans == T_BUSY) busy++;
      if (htrans != T_IDLE) begin
        if (exp_addr_q.size() == 0) begin
          checkOutput("htrans_after_last", htrans, T_IDLE);
        end else begin
          checkOutput("haddr", haddr, exp_addr_q[0].addr);
          if (htrans[1]) begin
            checkOutput("htrans", htrans, exp_addr_q[0].trans);
            checkOutput("hwrite", hwrite, 1);
            checkOutput("hsize", hsize, exp_size);
            checkOutput("hburst", hburst, 3'b001);
            if (hready) begin
              void'(exp_addr_q.pop_front());
              beats++;
              if (exp_data_q.size() > 0) data_exp = exp_data_q.pop_front();
              data_pend = 1'b1;
            end
          end
        end
      end
      if (v.err_cycle != 0 && c == v.err_cycle + 1)
        checkOutput("htrans_err_cycle2", htrans, T_IDLE);
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        checkOutput("done_pulse_width", done, 0);
        checkOutput("cmd_ready_after_done", cmd_ready, 1);
        @(posedge hclk); #1;
        break;
      end
      if (done === 1'b1 && done_cyc < 0) begin
        done_cyc = c;
        checkOutput("done_err", done_err, v.exp_err);
      end
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    checkOutput("done_cycle", done_cyc, v.exp_done);
    checkOutput("pops", pops, v.len + 1);
    checkOutput("beats", beats, v.exp_beats);
    checkOutput("busy_cycles", busy, v.exp_busy);
  endtask

  // Reset in the middle of a long burst: everything returns to idle at once
  // and no done pulse follows.
  task automatic resetMidBurst();
    int ndone;
    fifo_q.delete();
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'hC0DE0000 + i);
    cmd_valid = 1'b1; cmd_addr = 32'h5000; cmd_len = 8'd7; cmd_size = 3'd2;
    hready = 1'b1; hresp = 1'b0;
    for (int c = 0; c < 5; c++) begin
      fifo_empty = (fifo_q.size() == 0);
      fifo_rdata = fifo_empty ? '0 : fifo_q[0];
      @(negedge hclk);
      if (fifo_rd_en) void'(fifo_q.pop_front());
      @(posedge hclk); #1;
      cmd_valid = 1'b0;
    end
    resetn = 1'b0;
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? '0 : fifo_q[0];
    @(negedge hclk);
    checkOutput("rst_fifo_rd_en", fifo_rd_en, 0);
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    @(posedge hclk); #1;
    resetn = 1'b1;
    fifo_q.delete();
    fifo_empty = 1'b1;
    fifo_rdata = '0;
    @(negedge hclk);
    checkOutput("rst_htrans", htrans, T_IDLE);
    checkOutput("rst_haddr", haddr, 0);
    checkOutput("rst_hwdata", hwdata, 0);
    checkOutput("rst_hwrite", hwrite, 0);
    checkOutput("rst_cmd_ready_after", cmd_ready, 1);
    ndone = (done === 1'b1) ? 1 : 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge hclk); #1;
      @(negedge hclk);
      if (done === 1'b1) ndone++;
    end
    checkOutput("no_done_after_reset", ndone, 0);
    @(posedge hclk); #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    passed = 0;
    resetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
    fifo_empty = 1'b0; fifo_rdata = 32'h12345678; hready = 1'b1; hresp = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    @(negedge hclk);
    checkOutput("reset_htrans", htrans, T_IDLE);
    checkOutput("reset_haddr", haddr, 0);
    checkOutput("reset_hwdata", hwdata, 0);
    checkOutput("reset_hwrite", hwrite, 0);
    checkOutput("reset_hsize", hsize, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_done_err", done_err, 0);
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    checkOutput("reset_fifo_rd_en", fifo_rd_en, 0);
    @(posedge hclk); #1;
    resetn = 1'b1;
    fifo_empty = 1'b1;
    @(posedge hclk); #1;

    //            addr      len size pre push wst wln err done err beats busy
    vecs[0] = mk(32'h1000,   0, 3'd2, 1, -1, 0, 0, 0,  4, 1'b0, 1, 0);
    vecs[1] = mk(32'h2000,   3, 3'd2, 4, -1, 0, 0, 0,  7, 1'b0, 4, 0);
    vecs[2] = mk(32'h2000,   3, 3'd2, 2,  6, 0, 0, 0, 10, 1'b0, 4, 3);
    vecs[3] = mk(32'h03F8,   3, 3'd2, 4, -1, 0, 0, 0,  7, 1'b0, 4, 0);
    vecs[4] = mk(32'h2000,   3, 3'd2, 4, -1, 4, 2, 0,  9, 1'b0, 4, 0);
    vecs[5] = mk(32'h2000,   3, 3'd2, 4, -1, 0, 0, 4,  7, 1'b1, 2, 0);
    vecs[6] = mk(32'h6000,   1, 3'd3, 2, -1, 0, 0, 0,  5, 1'b0, 2, 0);
    vecs[7] = mk(32'h4001,   2, 3'd0, 3, -1, 0, 0, 0,  6, 1'b0, 3, 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], i);
    end

    resetMidBurst();
    applyStimulus(vecs[1], 9);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
